// File: rtl/modem_pkg.sv
// Shared modem definitions: FSM states and reserved sample words.
// Also used by the matching demodulator.
package modem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        GUARD,
        DATA
    } mod_state_e;

    localparam logic [15:0] SYNC_WORD  = 16'hFFFF;
    localparam logic [15:0] GUARD_WORD = 16'h0000;
    localparam logic [15:0] MARK_WORD  = 16'h7FFF;
    localparam logic [15:0] SPACE_WORD = 16'h8001;

    function automatic logic [15:0] bit_word(input logic b);
        return b ? MARK_WORD : SPACE_WORD;
    endfunction

endpackage

// File: rtl/digital_modulator.sv
// Frame modulator: sync burst, one guard sample, then 16 data bits
// MSB first, SPB samples per bit; back-to-back frames supported.
import modem_pkg::*;

module digital_modulator #(
    parameter int SPB      = 4,
    parameter int SYNC_LEN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] tx_sample,
    output logic        tx_valid,
    output logic        frame_done
);

    localparam int SW = (SPB > 1) ? $clog2(SPB) : 1;
    localparam int YW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
    localparam logic [SW-1:0] SMP_LAST = SW'(SPB - 1);
    localparam logic [YW-1:0] SYN_LAST = YW'(SYNC_LEN - 1);

    mod_state_e    state_q, state_d;
    logic [SW-1:0] smp_q, smp_d;
    logic [3:0]    bit_q, bit_d;
    logic [YW-1:0] syn_q, syn_d;
    logic [15:0]   shreg_q, shreg_d;
    logic [15:0]   tx_q, tx_d;
    logic          txv_q, txv_d;
    logic          fd_q, fd_d;

    logic last_smp;
    logic frame_end;
    logic accept;

    // The registered outputs always describe state_q, so the final
    // sample of a frame is visible here and can overlap a new handshake.
    assign last_smp  = (smp_q == SMP_LAST);
    assign frame_end = (state_q == DATA) && last_smp && (bit_q == 4'd0);
    assign s_ready   = rst_n && ((state_q == IDLE) || frame_end);
    assign accept    = s_valid && s_ready;

    assign tx_sample  = tx_q;
    assign tx_valid   = txv_q;
    assign frame_done = fd_q;

    // Next-state and counter sequencing.
    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        bit_d   = bit_q;
        syn_d   = syn_q;
        shreg_d = shreg_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SYNC;
                    syn_d   = '0;
                    shreg_d = s_data;
                end
            end
            SYNC: begin
                if (syn_q == SYN_LAST) begin
                    state_d = GUARD;
                    syn_d   = '0;
                end else begin
                    syn_d = syn_q + 1'b1;
                end
            end
            GUARD: begin
                state_d = DATA;
                bit_d   = 4'd15;
                smp_d   = '0;
            end
            DATA: begin
                if (last_smp) begin
                    smp_d = '0;
                    if (bit_q == 4'd0) begin
                        bit_d   = 4'd15;
                        syn_d   = '0;
                        state_d = accept ? SYNC : IDLE;
                        if (accept) begin
                            shreg_d = s_data;
                        end
                    end else begin
                        bit_d = bit_q - 4'd1;
                    end
                end else begin
                    smp_d = smp_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output word for the sample that the next state will present.
    always_comb begin
        tx_d  = GUARD_WORD;
        txv_d = 1'b0;
        fd_d  = 1'b0;
        unique case (state_d)
            SYNC: begin
                tx_d  = SYNC_WORD;
                txv_d = 1'b1;
            end
            GUARD: begin
                tx_d  = GUARD_WORD;
                txv_d = 1'b1;
            end
            DATA: begin
                tx_d  = bit_word(shreg_d[bit_d]);
                txv_d = 1'b1;
                fd_d  = (bit_d == 4'd0) && (smp_d == SMP_LAST);
            end
            default: ;
        endcase
    end

    // State, counters, shift register and output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            smp_q   <= '0;
            bit_q   <= '0;
            syn_q   <= '0;
            shreg_q <= '0;
            tx_q    <= GUARD_WORD;
            txv_q   <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            bit_q   <= bit_d;
            syn_q   <= syn_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            txv_q   <= txv_d;
            fd_q    <= fd_d;
        end
    end

endmodule

// File: tb/tb_digital_modulator.sv
// Bench for digital_modulator: two instances (SPB=4/SYNC_LEN=8 and
// SPB=1/SYNC_LEN=1) checked against a queue of expected samples.
module tb_digital_modulator;

    typedef struct {
        logic [15:0] s;
        logic        fd;
    } exp_t;

    typedef struct {
        int          d;
        logic [15:0] data;
        int          exp_len;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n;
    logic [1:0]       s_valid;
    logic [1:0]       s_ready;
    logic [1:0]       tx_v;
    logic [1:0]       fd;
    logic [1:0][15:0] s_data;
    logic [1:0][15:0] tx_s;

    int   spb [2] = '{4, 1};
    int   sl  [2] = '{8, 1};
    exp_t exp_q [2][$];
    int   cnt      [2] = '{0, 0};
    int   last_len [2] = '{0, 0};
    int   done_n   [2] = '{0, 0};
    int   tests = 0;
    int   fails = 0;

    digital_modulator #(.SPB(4), .SYNC_LEN(8)) u_a (
        .clk        (clk),
        .rst_n      (rst_n[0]),
        .s_data     (s_data[0]),
        .s_valid    (s_valid[0]),
        .s_ready    (s_ready[0]),
        .tx_sample  (tx_s[0]),
        .tx_valid   (tx_v[0]),
        .frame_done (fd[0])
    );

    digital_modulator #(.SPB(1), .SYNC_LEN(1)) u_b (
        .clk        (clk),
        .rst_n      (rst_n[1]),
        .s_data     (s_data[1]),
        .s_valid    (s_valid[1]),
        .s_ready    (s_ready[1]),
        .tx_sample  (tx_s[1]),
        .tx_valid   (tx_v[1]),
        .frame_done (fd[1])
    );

    function automatic void push_frame(input int d, input logic [15:0] w);
        exp_t e;
        for (int i = 0; i < sl[d]; i++) begin
            e.s  = 16'hFFFF;
            e.fd = 1'b0;
            exp_q[d].push_back(e);
        end
        e.s  = 16'h0000;
        e.fd = 1'b0;
        exp_q[d].push_back(e);
        for (int b = 15; b >= 0; b--) begin
            for (int k = 0; k < spb[d]; k++) begin
                e.s  = w[b] ? 16'h7FFF : 16'h8001;
                e.fd = (b == 0) && (k == spb[d] - 1);
                exp_q[d].push_back(e);
            end
        end
    endfunction

    task automatic chk(input string nm, input int d,
                       input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s dut%0d got=%h want=%h", nm, d, got, want);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    task automatic mon(input int d);
        exp_t e;
        tests++;
        if (tx_v[d] === 1'b1) begin
            if (exp_q[d].size() == 0) begin
                fails++;
                $display("FAIL unexpected_sample dut%0d got=%h want=none",
                         d, tx_s[d]);
            end else begin
                e = exp_q[d].pop_front();
                if (tx_s[d] !== e.s || fd[d] !== e.fd) begin
                    fails++;
                    $display("FAIL sample dut%0d idx=%0d got=%h/%b want=%h/%b",
                             d, cnt[d], tx_s[d], fd[d], e.s, e.fd);
                end
            end
            tests++;
            if (tx_s[d] === 16'hFFFF && cnt[d] >= sl[d]) begin
                fails++;
                $display("FAIL ffff_outside_sync dut%0d idx=%0d got=%h want=not_ffff",
                         d, cnt[d], tx_s[d]);
            end
            cnt[d]++;
            if (fd[d] === 1'b1) begin
                tests++;
                if (cnt[d] != sl[d] + 1 + 16 * spb[d]) begin
                    fails++;
                    $display("FAIL frame_count dut%0d got=%0d want=%0d",
                             d, cnt[d], sl[d] + 1 + 16 * spb[d]);
                end
                last_len[d] = cnt[d];
                done_n[d]++;
                cnt[d] = 0;
            end
        end else if (tx_v[d] !== 1'b0 || tx_s[d] !== 16'h0000 ||
                     fd[d] !== 1'b0 || exp_q[d].size() != 0) begin
            fails++;
            $display("FAIL idle dut%0d got=%b/%h/%b want=0/0000/0 pend=%0d",
                     d, tx_v[d], tx_s[d], fd[d], exp_q[d].size());
        end
        if (rst_n[d] === 1'b0) begin
            tests++;
            if (s_ready[d] !== 1'b0) begin
                fails++;
                $display("FAIL ready_in_reset dut%0d got=%b want=0", d, s_ready[d]);
            end
            exp_q[d].delete();
            cnt[d] = 0;
        end else if (s_valid[d] === 1'b1 && s_ready[d] === 1'b1) begin
            push_frame(d, s_data[d]);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon(d);
    end

    task automatic send(input int d, input logic [15:0] w, input bit keep);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        s_valid[d] = 1'b1;
        s_data[d]  = w;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_ready[d] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) s_valid[d] = 1'b0;
        chk("handshake", d, 32'(ok), 32'd1);
    endtask

    task automatic wait_fd(input int d, output int len);
        int  start;
        bit  ok;
        start = done_n[d];
        ok    = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (done_n[d] != start) begin
                ok = 1'b1;
                break;
            end
        end
        len = ok ? last_len[d] : -1;
    endtask

    vec_t vecs [7];
    int   len;
    int   seen;
    bit   ok;

    initial begin
        rst_n   = 2'b00;
        s_valid = 2'b00;
        s_data  = '0;

        vecs[0] = '{0, 16'hA5A5, 73};
        vecs[1] = '{0, 16'h0000, 73};
        vecs[2] = '{0, 16'hFFFF, 73};
        vecs[3] = '{0, 16'h1234, 73};
        vecs[4] = '{1, 16'h8001, 18};
        vecs[5] = '{1, 16'hFFFF, 18};
        vecs[6] = '{1, 16'h0001, 18};

        repeat (3) @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("rst_tx_valid", d, 32'(tx_v[d]), 32'd0);
            chk("rst_tx_sample", d, 32'(tx_s[d]), 32'h0000);
            chk("rst_frame_done", d, 32'(fd[d]), 32'd0);
            chk("rst_s_ready", d, 32'(s_ready[d]), 32'd0);
        end
        rst_n = 2'b11;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("idle_s_ready", d, 32'(s_ready[d]), 32'd1);
        end

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].d, vecs[i].data, 1'b0);
            wait_fd(vecs[i].d, len);
            chk("frame_len", vecs[i].d, len, vecs[i].exp_len);
        end

        // Back-to-back: FFFF then 0000 with s_valid held high.
        send(0, 16'hFFFF, 1'b1);
        s_data[0] = 16'h0000;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_ready[0] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("b2b_ready", 0, 32'(ok), 32'd1);
        chk("b2b_fd_at_ready", 0, 32'(fd[0]), 32'd1);
        @(posedge clk);
        #1;
        s_valid[0] = 1'b0;
        #1;
        chk("b2b_next_valid", 0, 32'(tx_v[0]), 32'd1);
        chk("b2b_next_sync", 0, 32'(tx_s[0]), 32'hFFFF);
        wait_fd(0, len);
        chk("b2b_len", 0, len, 73);
        repeat (2) @(posedge clk);
        #2;
        chk("b2b_then_idle", 0, 32'(tx_v[0]), 32'd0);

        // s_valid pulsed on sample 20 of a frame.
        send(0, 16'h5A5A, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        s_data[0]  = 16'h1111;
        s_valid[0] = 1'b1;
        #1;
        chk("busy_s_ready", 0, 32'(s_ready[0]), 32'd0);
        @(posedge clk);
        #1;
        s_valid[0] = 1'b0;
        wait_fd(0, len);
        chk("busy_len", 0, len, 73);

        // One-cycle reset in the middle of DATA.
        send(0, 16'hC3C3, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        rst_n[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        #1;
        chk("abort_tx_valid", 0, 32'(tx_v[0]), 32'd0);
        chk("abort_tx_sample", 0, 32'(tx_s[0]), 32'h0000);
        chk("abort_frame_done", 0, 32'(fd[0]), 32'd0);
        seen = 0;
        repeat (100) begin
            @(posedge clk);
            #2;
            if (tx_v[0] !== 1'b0) seen++;
        end
        chk("abort_no_replay", 0, seen, 0);
        chk("abort_ready", 0, 32'(s_ready[0]), 32'd1);

        for (int d = 0; d < 2; d++) begin
            chk("queue_drained", d, exp_q[d].size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
